// File: rtl/mprj_logic1_seq.sv
// rtl/mprj_logic1_seq.sv - staggered, debounced per-domain logic1 release; MPRJ_PWR_SEQ_BROWNOUT_EN adds brownout drop and sticky faults
module mprj_logic1_seq #(
    parameter int NUM_DOMAINS     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int STAGGER_CYCLES  = 4
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic [NUM_DOMAINS-1:0] pwr_good_i,
    input  logic [NUM_DOMAINS-1:0] enable_i,
    input  logic                   fault_clr_i,
    output logic [NUM_DOMAINS-1:0] mprj_vdd_logic1,
    output logic                   seq_done_o,
    output logic [NUM_DOMAINS-1:0] fault_o
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int GW = $clog2(STAGGER_CYCLES) + 1;
    localparam int IW = $clog2(NUM_DOMAINS + 1);
    localparam int PW = 1 << IW;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(STAGGER_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DOMAINS - 1);
    localparam logic [IW-1:0] IDX_END  = IW'(NUM_DOMAINS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_DEBOUNCE,
        S_GAP,
        S_DONE
    } state_t;

    state_t                 state;
    logic [CW-1:0]          cnt;
    logic [GW-1:0]          gap;
    logic [IW-1:0]          idx;
    logic [NUM_DOMAINS-1:0] sync_q;
    logic [NUM_DOMAINS-1:0] good_s;
    logic [NUM_DOMAINS-1:0] en_q;
    logic [NUM_DOMAINS-1:0] en_rise;
    logic [PW-1:0]          en_pad;
    logic [PW-1:0]          good_pad;
    logic [PW-1:0]          on_pad;
    logic [PW-1:0]          sel_pad;
    logic                   rel_hit;
    logic [NUM_DOMAINS-1:0] rel_v;
    logic [NUM_DOMAINS-1:0] brown_v;
    logic [NUM_DOMAINS-1:0] logic1_next;

    // Padded copies let idx safely address the one-past-the-end value.
    assign en_pad   = PW'(enable_i);
    assign good_pad = PW'(good_s);
    assign on_pad   = PW'(mprj_vdd_logic1);
    assign sel_pad  = PW'(1) << idx;

    assign rel_hit = (state == S_DEBOUNCE) && en_pad[idx] && good_pad[idx] && (cnt == CNT_LAST);
    assign rel_v   = rel_hit ? sel_pad[NUM_DOMAINS-1:0] : '0;

`ifdef MPRJ_PWR_SEQ_BROWNOUT_EN
    assign brown_v = mprj_vdd_logic1 & ~good_s;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            fault_o <= '0;
        end else begin
            fault_o <= (fault_o & ~{NUM_DOMAINS{fault_clr_i}}) | brown_v;
        end
    end
`else
    logic unused_fault_clr;
    assign unused_fault_clr = fault_clr_i;
    assign brown_v          = '0;
    assign fault_o          = '0;
`endif

    // Withdrawal and brownout both override a same-cycle release.
    assign logic1_next = (mprj_vdd_logic1 | rel_v) & enable_i & ~brown_v;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            sync_q          <= '0;
            good_s          <= '0;
            en_q            <= '0;
            en_rise         <= '0;
            mprj_vdd_logic1 <= '0;
            seq_done_o      <= 1'b0;
            state           <= S_IDLE;
            cnt             <= '0;
            gap             <= '0;
            idx             <= '0;
        end else begin
            sync_q          <= pwr_good_i;
            good_s          <= sync_q;
            en_q            <= enable_i;
            en_rise         <= enable_i & ~en_q;
            mprj_vdd_logic1 <= logic1_next;
            case (state)
                S_IDLE: begin
                    idx   <= '0;
                    state <= S_CHECK;
                end
                S_CHECK: begin
                    if (idx == IDX_END) begin
                        state      <= S_DONE;
                        seq_done_o <= 1'b1;
                    end else if (!en_pad[idx] || on_pad[idx]) begin
                        idx <= idx + 1'b1;
                    end else begin
                        cnt   <= '0;
                        state <= S_DEBOUNCE;
                    end
                end
                S_DEBOUNCE: begin
                    if (!en_pad[idx]) begin
                        idx   <= idx + 1'b1;
                        state <= S_CHECK;
                    end else if (!good_pad[idx]) begin
                        cnt <= '0;
                    end else if (cnt == CNT_LAST) begin
                        gap   <= '0;
                        state <= S_GAP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_GAP: begin
                    gap <= gap + 1'b1;
                    // No inrush to stagger after the highest domain.
                    if (gap == GAP_LAST || idx == IDX_LAST) begin
                        idx   <= idx + 1'b1;
                        state <= S_CHECK;
                    end
                end
                S_DONE: begin
                    if ((|en_rise) || (|brown_v)) begin
                        idx        <= '0;
                        state      <= S_CHECK;
                        seq_done_o <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mprj_logic1_seq.sv
// tb/tb_mprj_logic1_seq.sv - table and scoreboard bench for mprj_logic1_seq
module tb_mprj_logic1_seq;
    localparam int NEVER = 9999;
`ifdef MPRJ_PWR_SEQ_BROWNOUT_EN
    localparam bit BROWN = 1'b1;
`else
    localparam bit BROWN = 1'b0;
`endif

    logic       wb_clk_i = 1'b0;
    logic       wb_rst_i = 1'b1;
    logic [1:0] pwr_good_i = 2'b11;
    logic [1:0] enable_i = 2'b11;
    logic       fault_clr_i = 1'b0;
    logic [1:0] mprj_vdd_logic1;
    logic       seq_done_o;
    logic [1:0] fault_o;

    mprj_logic1_seq dut (
        .wb_clk_i        (wb_clk_i),
        .wb_rst_i        (wb_rst_i),
        .pwr_good_i      (pwr_good_i),
        .enable_i        (enable_i),
        .fault_clr_i     (fault_clr_i),
        .mprj_vdd_logic1 (mprj_vdd_logic1),
        .seq_done_o      (seq_done_o),
        .fault_o         (fault_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    typedef struct {
        string      name;
        logic [1:0] en;
        int         glitch;
        int         r0;
        int         r1;
        int         d;
    } vec_t;

    typedef struct {
        string      name;
        int         edge_n;
        logic [4:0] exp;
    } sb_t;

    vec_t vecs[5];
    sb_t  sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic set_vec(input int i, input string name, input logic [1:0] en,
                           input int glitch, input int r0, input int r1, input int d);
        vecs[i].name   = name;
        vecs[i].en     = en;
        vecs[i].glitch = glitch;
        vecs[i].r0     = r0;
        vecs[i].r1     = r1;
        vecs[i].d      = d;
    endtask

    // exp packs {fault_o, seq_done_o, mprj_vdd_logic1}
    task automatic step(input string name, input int e, input logic [1:0] en,
                        input logic [1:0] good, input logic clr, input logic [4:0] exp);
        sb_t        it;
        logic [4:0] got;
        @(negedge wb_clk_i);
        wb_rst_i    = 1'b0;
        enable_i    = en;
        pwr_good_i  = good;
        fault_clr_i = clr;
        it.name   = name;
        it.edge_n = e;
        it.exp    = exp;
        sb_q.push_back(it);
        @(posedge wb_clk_i);
        #1;
        got = {fault_o, seq_done_o, mprj_vdd_logic1};
        it  = sb_q.pop_front();
        checks++;
        if (got !== it.exp) begin
            errors++;
            $display("FAIL %s edge %0d: got {fault,done,logic1}=%b expected %b",
                     it.name, it.edge_n, got, it.exp);
        end
    endtask

    task automatic do_reset(input string name, input logic [1:0] en);
        logic [4:0] got;
        @(negedge wb_clk_i);
        wb_rst_i    = 1'b1;
        enable_i    = en;
        pwr_good_i  = 2'b11;
        fault_clr_i = 1'b0;
        @(posedge wb_clk_i);
        #1;
        got = {fault_o, seq_done_o, mprj_vdd_logic1};
        checks++;
        if (got !== 5'b0) begin
            errors++;
            $display("FAIL %s reset: got %b expected 00000", name, got);
        end
    endtask

    task automatic run_vec(input int i, input int last);
        logic [4:0] exp;
        logic [1:0] good;
        do_reset(vecs[i].name, vecs[i].en);
        for (int e = 1; e <= last; e++) begin
            good = (e == vecs[i].glitch) ? 2'b10 : 2'b11;
            exp  = {2'b00, e >= vecs[i].d, e >= vecs[i].r1, e >= vecs[i].r0};
            step(vecs[i].name, e, vecs[i].en, good, 1'b0, exp);
        end
    endtask

    initial begin
        logic [4:0] exp;
        logic       l0;
        logic       dn;
        logic       f0;

        set_vec(0, "power_up",  2'b11, 0,     18,    39,    41);
        set_vec(1, "glitch",    2'b11, 10,    28,    49,    51);
        set_vec(2, "disabled0", 2'b10, 0,     NEVER, 19,    21);
        set_vec(3, "only_dom0", 2'b01, 0,     18,    NEVER, 24);
        set_vec(4, "none_en",   2'b00, 0,     NEVER, NEVER, 4);

        for (int i = 0; i < 5; i++) run_vec(i, 60);

        // Late enable of domain 0 from DONE; domain 1 must stay high.
        run_vec(2, 60);
        for (int e = 61; e <= 90; e++) begin
            exp = {2'b00, (e < 62) || (e >= 85), 1'b1, e >= 79};
            step("late_enable", e, 2'b11, 2'b11, 1'b0, exp);
        end

        // Enable withdrawal while in DONE.
        run_vec(0, 60);
        for (int e = 61; e <= 66; e++) begin
            step("withdraw", e, 2'b01, 2'b11, 1'b0, 5'b00101);
        end

        // Three-cycle brownout on domain 0, then fault clear.
        run_vec(0, 60);
        for (int e = 61; e <= 95; e++) begin
            l0  = BROWN ? !((e >= 63) && (e < 81)) : 1'b1;
            dn  = BROWN ? !((e >= 63) && (e < 87)) : 1'b1;
            f0  = BROWN ? ((e >= 63) && (e < 90)) : 1'b0;
            exp = {1'b0, f0, dn, 1'b1, l0};
            step("brownout", e, 2'b11, (e >= 61 && e <= 63) ? 2'b10 : 2'b11, e == 90, exp);
        end

        // Reset during domain 1 debounce, then identical power-up.
        run_vec(0, 30);
        run_vec(0, 60);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end
endmodule

// File: doc/mprj_logic1_seq.md
# mprj_logic1_seq

Parametrised, sequenced generator of the user-project "logic high" enables in the 1.8 V domain. Each of `NUM_DOMAINS` user power domains gets a `mprj_vdd_logic1` output. A domain's output is released only after three conditions hold: its power-good indication has been stable for a programmed number of cycles, the management core enables it, and all lower-indexed domains have been handled. Releases are staggered in index order to limit inrush. The block sits in the management protection path, feeding the per-domain logic1 signals that gate the user-project isolation.

## Interface
- `NUM_DOMAINS`, 2: number of user power domains (1..8).
- `DEBOUNCE_CYCLES`, 16: consecutive synchronised good cycles required before release (>= 1).
- `STAGGER_CYCLES`, 4: idle cycles between one release and the next domain's check (>= 1).

- `wb_clk_i`  input  1  block clock.
- `wb_rst_i`  input  1  synchronous, active-high reset.
- `pwr_good_i`  input  NUM_DOMAINS  raw per-domain power-good, asynchronous to `wb_clk_i`.
- `enable_i`  input  NUM_DOMAINS  per-domain enable from management logic, synchronous.
- `fault_clr_i`  input  1  single-cycle pulse that clears all `fault_o` bits.
- `mprj_vdd_logic1`  output  NUM_DOMAINS  per-domain logic-high enable, registered.
- `seq_done_o`  output  1  high while the FSM is in DONE.
- `fault_o`  output  NUM_DOMAINS  sticky brownout flag per domain.

## Operation
- Each `pwr_good_i` bit passes through a 2-flop synchroniser (`good_s`). The synchroniser flops clear on reset.
- One shared FSM with index register `idx`, debounce counter `cnt` and gap counter `gap`:
  - IDLE: set `idx`=0, go to CHECK.
  - CHECK: take the first matching case in this order:
    - If `idx`==NUM_DOMAINS, go to DONE.
    - If `enable_i[idx]`=0, or `mprj_vdd_logic1[idx]` is already 1, increment `idx` and stay in CHECK.
    - Otherwise clear `cnt` and go to DEBOUNCE.
  - DEBOUNCE: if `good_s[idx]`=0, clear `cnt`. If `good_s[idx]`=1 and `cnt`==DEBOUNCE_CYCLES-1, set `mprj_vdd_logic1[idx]`, clear `gap` and go to GAP. Otherwise increment `cnt`. If `enable_i[idx]` drops, increment `idx` and return to CHECK.
  - GAP: increment `gap`. When `gap`==STAGGER_CYCLES-1, increment `idx` and go to CHECK.
  - DONE: `seq_done_o`=1. Any `enable_i` rising edge (registered compare) returns the FSM to CHECK with `idx`=0. Domains that are already on are skipped, so their outputs do not glitch.
- Enable withdrawal: `enable_i[k]`=0 in any state clears `mprj_vdd_logic1[k]` on the next edge.
- Widths:
  - `cnt` is $clog2(DEBOUNCE_CYCLES)+1 bits.
  - `gap` is $clog2(STAGGER_CYCLES)+1 bits.
  - `idx` is $clog2(NUM_DOMAINS+1) bits.
  - No counter wraps; comparisons are equality-terminated.
- Simultaneous events:
  - Enable withdrawal beats release in the same cycle.
  - `fault_clr_i` coincident with a new fault leaves that fault bit set.

## Timing
- Reset values:
  - `mprj_vdd_logic1`=0, `seq_done_o`=0, `fault_o`=0.
  - FSM=IDLE; `cnt`, `gap` and `idx` = 0.
  - Synchronisers = 0.
- Reset mid-sequence: all outputs return to 0 on the edge that samples `wb_rst_i`=1, and the sequence restarts from IDLE.
- Edge numbering: the first edge with `wb_rst_i`=0 is edge 1. Assume all goods and enables are stable high.
  - Domain 0 rises after edge DEBOUNCE_CYCLES+2.
  - Each subsequent domain rises DEBOUNCE_CYCLES+STAGGER_CYCLES+1 edges after the previous one.
- Latency from `pwr_good_i` rising, with the FSM waiting in DEBOUNCE for that domain, to output high: DEBOUNCE_CYCLES+2 edges.
- `seq_done_o` rises 2 edges after the last release: one edge leaves GAP, one edge leaves CHECK.

## Configuration
- `MPRJ_PWR_SEQ_BROWNOUT_EN` defined:
  - While `mprj_vdd_logic1[k]`=1, `good_s[k]`=0 for one cycle clears `mprj_vdd_logic1[k]` and sets `fault_o[k]`, both on the next edge.
  - If the FSM is in DONE, it returns to CHECK with `idx`=0, and the domain re-debounces before release.
  - `fault_o[k]` clears only on `fault_clr_i` or reset.
- Macro not defined:
  - Once released, a domain ignores `pwr_good_i` until its enable drops or reset.
  - `fault_o` is tied to 0 and `fault_clr_i` is unused.

## Test plan
- Power-up, NUM_DOMAINS=2, DEBOUNCE_CYCLES=16, STAGGER_CYCLES=4, goods and enables high from reset -> `mprj_vdd_logic1[0]` high after edge 18, `[1]` after edge 39, `seq_done_o` after edge 41. All outputs 0 before those edges.
- Glitching good: `pwr_good_i[0]` pulses low for 1 cycle at edge 10 -> `cnt` restarts and domain 0 release moves later by the pulse offset plus 2 sync cycles. Domain 1 never rises before domain 0.
- Disabled domain: `enable_i`=2'b10 -> domain 0 stays 0, domain 1 rises after edge 19, `seq_done_o` after edge 21. Then raise `enable_i[0]` -> domain 0 rises DEBOUNCE_CYCLES+3 edges later and domain 1 stays high throughout.
- Enable withdrawal in DONE: drop `enable_i[1]` -> `mprj_vdd_logic1[1]`=0 on the next edge and domain 0 is unaffected.
- Brownout (macro defined): in DONE, drop `pwr_good_i[0]` for 3 cycles -> output 0 and `fault_o[0]`=1 three edges after the drop. Domain 0 re-releases 16 debounce cycles after good returns. `fault_clr_i` pulse clears `fault_o[0]`. With the macro undefined, the same stimulus leaves the output high and `fault_o`=0.
- Reset mid-DEBOUNCE of domain 1 -> all outputs 0 on the next edge, and the exact power-up timing repeats.
